risp_input_scheduler: RTL and testbench

- Producer side of a risp neuron's charge input. Accepts externally injected spikes (delay, charge) over a valid/ready handshake and buffers them in a ring of per-timestep charge slots.
- On each enabled timestep, presents the accumulated charge for that timestep on one signed charge lane.
- Sits between the host spike decoder and an input neuron's charge port.
- Also provides the quiescence flag used by "run until idle".

---
 rtl/risp_pkg.sv | 32 +++
 rtl/risp_input_scheduler_if.sv | 13 +
 rtl/risp_charge_ring.sv | 62 ++++++
 rtl/risp_input_scheduler.sv | 76 +++++++
 tb/tb_risp_input_scheduler.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/risp_pkg.sv
// Shared types and saturating arithmetic for the risp input path.
// Sums are formed at full integer width and then clamped to a signed lane of the requested width.
package risp_pkg;

  localparam int CHARGE_WIDTH_DEF = 8;
  localparam int DELAY_WIDTH_DEF  = 4;

  typedef logic signed [CHARGE_WIDTH_DEF-1:0] charge_t;

  function automatic logic signed [31:0] sat_max(input int width);
    return (32'sd1 <<< (width - 1)) - 32'sd1;
  endfunction

  function automatic logic signed [31:0] sat_min(input int width);
    return -(32'sd1 <<< (width - 1));
  endfunction

  // Operands are sign-extended lane values, so the 32-bit sum never wraps.
  function automatic logic signed [31:0] sat_add_signed(input logic signed [31:0] a,
                                                         input logic signed [31:0] b,
                                                         input int                 width);
    logic signed [31:0] sum;
    sum = a + b;
    if (sum > sat_max(width)) begin
      return sat_max(width);
    end else if (sum < sat_min(width)) begin
      return sat_min(width);
    end
    return sum;
  endfunction

endpackage

// File: rtl/risp_input_scheduler_if.sv
// Spike injection handshake: the source offers (delay, charge) and holds it until spk_rdy.
interface risp_input_scheduler_if #(
  parameter int CHARGE_WIDTH = 8,
  parameter int DELAY_WIDTH  = 4
);
  logic                           spk_vld;
  logic                           spk_rdy;
  logic [DELAY_WIDTH-1:0]         spk_delay;
  logic signed [CHARGE_WIDTH-1:0] spk_charge;

  modport master (output spk_vld, output spk_delay, output spk_charge, input spk_rdy);
  modport slave  (input spk_vld, input spk_delay, input spk_charge, output spk_rdy);
endinterface

// File: rtl/risp_charge_ring.sv
// Ring of per-timestep charge slots with head pointer and nonzero bitmap.
// Deposit writes one slot; retire zeroes the head slot and advances; clear wins over both.
module risp_charge_ring #(
  parameter int CHARGE_WIDTH = 8,
  parameter int DELAY_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    arstn,
  input  logic                    clr_i,
  input  logic                    retire_i,
  input  logic                    dep_vld_i,
  input  logic [DELAY_WIDTH-1:0]  dep_idx_i,
  input  logic [CHARGE_WIDTH-1:0] dep_val_i,
  output logic [CHARGE_WIDTH-1:0] dep_old_o,
  output logic [CHARGE_WIDTH-1:0] head_val_o,
  output logic [DELAY_WIDTH-1:0]  head_o,
  output logic                    idle_o
);
  localparam int DEPTH = 2 ** DELAY_WIDTH;

  logic [CHARGE_WIDTH-1:0] slot_q [DEPTH];
  logic [CHARGE_WIDTH-1:0] slot_d [DEPTH];
  logic [DEPTH-1:0]        nz_q, nz_d;
  logic [DELAY_WIDTH-1:0]  head_q, head_d;

  always_comb begin
    slot_d = slot_q;
    nz_d   = nz_q;
    head_d = head_q;
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) slot_d[i] = '0;
      nz_d   = '0;
      head_d = '0;
    end else if (retire_i) begin
      slot_d[head_q] = '0;
      nz_d[head_q]   = 1'b0;
      head_d         = head_q + 1'b1;
    end else if (dep_vld_i) begin
      // A deposit that cancels the slot back to zero drops its bitmap bit.
      slot_d[dep_idx_i] = dep_val_i;
      nz_d[dep_idx_i]   = |dep_val_i;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      nz_q   <= '0;
      head_q <= '0;
    end else begin
      slot_q <= slot_d;
      nz_q   <= nz_d;
      head_q <= head_d;
    end
  end

  assign dep_old_o  = slot_q[dep_idx_i];
  assign head_val_o = slot_q[head_q];
  assign head_o     = head_q;
  assign idle_o     = (nz_q == '0);

endmodule

// File: rtl/risp_input_scheduler.sv
// Buffers injected spikes into timestep slots and presents the head slot as charge (0-cycle read).
// spk_rdy drops during en/clr/reset so deposits never race a slot retire; the source holds the spike.
module risp_input_scheduler
  import risp_pkg::*;
#(
  parameter int CHARGE_WIDTH = 8,
  parameter int DELAY_WIDTH  = 4
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic                           clr,
  input  logic                           en,
  risp_input_scheduler_if.slave          spk,
  output logic signed [CHARGE_WIDTH-1:0] charge,
  output logic                           idle,
  output logic                           sat
);
  logic                    accept;
  logic [DELAY_WIDTH-1:0]  head;
  logic [DELAY_WIDTH-1:0]  dep_idx;
  logic [CHARGE_WIDTH-1:0] dep_old;
  logic [CHARGE_WIDTH-1:0] dep_new;
  logic [CHARGE_WIDTH-1:0] head_val;
  logic signed [31:0]      sum_raw;
  logic signed [31:0]      sum_clamped;
  logic                    sat_hit;
  logic                    sat_q, sat_d;

  assign spk.spk_rdy = arstn && !clr && !en;
  assign accept      = spk.spk_vld && spk.spk_rdy;
  assign dep_idx     = head + spk.spk_delay;

  assign sum_raw     = 32'(signed'(dep_old)) + 32'(signed'(spk.spk_charge));
  assign sum_clamped = sat_add_signed(32'(signed'(dep_old)), 32'(signed'(spk.spk_charge)),
                                      CHARGE_WIDTH);
  assign sat_hit     = (sum_raw != sum_clamped);
  assign dep_new     = sum_clamped[CHARGE_WIDTH-1:0];

  risp_charge_ring #(
    .CHARGE_WIDTH (CHARGE_WIDTH),
    .DELAY_WIDTH  (DELAY_WIDTH)
  ) u_ring (
    .clk        (clk),
    .arstn      (arstn),
    .clr_i      (clr),
    .retire_i   (en),
    .dep_vld_i  (accept),
    .dep_idx_i  (dep_idx),
    .dep_val_i  (dep_new),
    .dep_old_o  (dep_old),
    .head_val_o (head_val),
    .head_o     (head),
    .idle_o     (idle)
  );

  always_comb begin
    sat_d = sat_q;
    if (clr) begin
      sat_d = 1'b0;
    end else if (accept && sat_hit) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat    = sat_q;
  assign charge = signed'(head_val);

endmodule

// File: tb/tb_risp_input_scheduler.sv
// Scoreboarded bench: the driver models the slot ring with plain integers, the monitor checks every en cycle.
module tb_risp_input_scheduler;
  localparam int CW    = 8;
  localparam int DW    = 4;
  localparam int DEPTH = 16;
  localparam int CMAX  = 127;
  localparam int CMIN  = -128;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  logic clr = 1'b0;
  logic en = 1'b0;
  logic signed [CW-1:0] charge;
  logic idle;
  logic sat;

  risp_input_scheduler_if #(.CHARGE_WIDTH(CW), .DELAY_WIDTH(DW)) spk_if ();

  risp_input_scheduler #(.CHARGE_WIDTH(CW), .DELAY_WIDTH(DW)) dut (
    .clk    (clk),
    .arstn  (arstn),
    .clr    (clr),
    .en     (en),
    .spk    (spk_if.slave),
    .charge (charge),
    .idle   (idle),
    .sat    (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int charge;
    bit idle;
    bit sat;
  } exp_t;

  exp_t sb_q[$];
  int   m_slot[DEPTH];
  int   m_head = 0;
  bit   m_sat = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   done = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit m_idle();
    foreach (m_slot[i]) if (m_slot[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_clear();
    foreach (m_slot[i]) m_slot[i] = 0;
    m_head = 0;
    m_sat  = 1'b0;
  endfunction

  function automatic void m_accept(input int d, input int c);
    int idx;
    int s;
    idx = (m_head + d) % DEPTH;
    s   = m_slot[idx] + c;
    if (s > CMAX) begin
      s = CMAX;
      m_sat = 1'b1;
    end else if (s < CMIN) begin
      s = CMIN;
      m_sat = 1'b1;
    end
    m_slot[idx] = s;
  endfunction

  function automatic void m_expect_and_advance();
    exp_t e;
    e.charge = m_slot[m_head];
    e.idle   = m_idle();
    e.sat    = m_sat;
    sb_q.push_back(e);
    m_slot[m_head] = 0;
    m_head = (m_head + 1) % DEPTH;
  endfunction

  // All driver tasks start and end 1 time unit after a posedge.
  task automatic step();
    en = 1'b1;
    m_expect_and_advance();
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic spike(input int d, input int c);
    spk_if.spk_vld    = 1'b1;
    spk_if.spk_delay  = DW'(d);
    spk_if.spk_charge = CW'(c);
    m_accept(d, c);
    @(posedge clk); #1;
    spk_if.spk_vld = 1'b0;
  endtask

  task automatic hold_then_accept(input int n, input int d, input int c);
    spk_if.spk_vld    = 1'b1;
    spk_if.spk_delay  = DW'(d);
    spk_if.spk_charge = CW'(c);
    for (int i = 0; i < n; i++) begin
      en = 1'b1;
      m_expect_and_advance();
      @(posedge clk); #1;
    end
    en = 1'b0;
    m_accept(d, c);
    @(posedge clk); #1;
    spk_if.spk_vld = 1'b0;
  endtask

  task automatic clr_cycle(input bit with_en);
    exp_t e;
    clr               = 1'b1;
    en                = with_en;
    spk_if.spk_vld    = 1'b1;
    spk_if.spk_delay  = 4'd0;
    spk_if.spk_charge = 8'sd50;
    if (with_en) begin
      e.charge = m_slot[m_head];
      e.idle   = m_idle();
      e.sat    = m_sat;
      sb_q.push_back(e);
    end
    m_clear();
    @(posedge clk); #1;
    clr            = 1'b0;
    en             = 1'b0;
    spk_if.spk_vld = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!done) begin
      check("spk_rdy", int'(spk_if.spk_rdy), int'(arstn && !clr && !en));
      if (en) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: en cycle with no expectation at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          check("charge", int'(charge), e.charge);
          check("idle", int'(idle), int'(e.idle));
          check("sat", int'(sat), int'(e.sat));
        end
      end
    end
  end

  initial begin
    int r;
    int c;
    spk_if.spk_vld    = 1'b0;
    spk_if.spk_delay  = '0;
    spk_if.spk_charge = '0;
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_charge", int'(charge), 0);
    check("rst_idle", int'(idle), 1);
    check("rst_sat", int'(sat), 0);
    check("rst_rdy", int'(spk_if.spk_rdy), 0);
    arstn = 1'b1;
    @(posedge clk); #1;

    repeat (3) step();

    spike(0, 5);
    step();
    step();

    spike(3, 7);
    check("idle_after_accept", int'(idle), 0);
    spike(3, -2);
    spike(1, 1);
    repeat (4) step();
    check("idle_after_drain", int'(idle), 1);

    spike(2, 100);
    spike(2, 100);
    repeat (3) step();
    spike(5, -128);
    spike(5, -1);
    repeat (6) step();

    while (m_head != 14) step();
    spike(3, 9);
    repeat (4) step();
    hold_then_accept(3, 0, 4);
    step();

    spike(2, 33);
    spike(6, 120);
    spike(6, 120);
    clr_cycle(1'b1);
    check("clr_idle", int'(idle), 1);
    check("clr_sat", int'(sat), 0);
    step();
    repeat (7) step();

    spike(1, 44);
    spike(4, -100);
    spike(4, -100);
    spk_if.spk_vld    = 1'b1;
    spk_if.spk_delay  = 4'd2;
    spk_if.spk_charge = 8'sd17;
    #2;
    arstn = 1'b0;
    #1;
    check("arst_charge", int'(charge), 0);
    check("arst_idle", int'(idle), 1);
    check("arst_sat", int'(sat), 0);
    check("arst_rdy", int'(spk_if.spk_rdy), 0);
    m_clear();
    @(posedge clk); #1;
    spk_if.spk_vld = 1'b0;
    arstn = 1'b1;
    @(posedge clk); #1;
    repeat (5) step();

    for (int it = 0; it < 500; it++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0) c = int'($urandom_range(0, 255)) - 128;
      else c = int'($urandom_range(0, 40)) - 20;
      if (r < 48) spike(int'($urandom_range(0, DEPTH - 1)), c);
      else if (r < 94) step();
      else if (r < 97) clr_cycle(bit'($urandom_range(0, 1)));
      else hold_then_accept(int'($urandom_range(1, 3)), int'($urandom_range(0, DEPTH - 1)), c);
    end
    repeat (DEPTH) step();

    @(posedge clk); #1;
    done = 1'b1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
